// File: rtl/vgroup_sequencer_if.sv
// Decode-side and issue-side valid/ready bundle of the vector group sequencer.
// master: upstream decode and downstream issue. slave: the sequencer itself.
interface vgroup_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int IDX_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_raA;
  logic [ADDR_W-1:0] in_raB;
  logic [ADDR_W-1:0] in_rdest;
  logic [2:0]        in_lmul;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_raA;
  logic [ADDR_W-1:0] out_raB;
  logic [ADDR_W-1:0] out_rdest;
  logic [IDX_W-1:0]  out_idx;
  logic              out_first;
  logic              out_last;

  modport master (
    output in_valid, in_raA, in_raB, in_rdest, in_lmul,
    output out_ready,
    input  in_ready,
    input  out_valid, out_raA, out_raB, out_rdest,
    input  out_idx, out_first, out_last
  );

  modport slave (
    input  in_valid, in_raA, in_raB, in_rdest, in_lmul,
    input  out_ready,
    output in_ready,
    output out_valid, out_raA, out_raB, out_rdest,
    output out_idx, out_first, out_last
  );
endinterface

// File: rtl/vgroup_sequencer.sv
// Expands one vector instruction into LMUL per-register micro-ops,
// one per cycle, stalling fetch while a register group is in flight.
module vgroup_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int MAX_LMUL = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  vgroup_sequencer_if.slave    bus,
  output logic                 fetch_stall,
  output logic                 illegal
);

  localparam int IDX_W = $clog2(MAX_LMUL);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_d;
  logic [IDX_W-1:0]  size_m1;
  logic [IDX_W-1:0]  idx;
  logic              illegal_q;

  logic [IDX_W-1:0]  dec_size_m1;
  logic              dec_rsvd;
  logic [ADDR_W-1:0] align_mask;
  logic              dec_misalign;
  logic              dec_bad;

  logic              issuing;
  logic              at_last;
  logic              out_fire;
  logic              in_fire;
  logic              ready;

  // Fractional encodings collapse to a single-register group.
  always_comb begin
    dec_size_m1 = '0;
    dec_rsvd    = 1'b0;
    unique case (bus.in_lmul)
      3'b000:  dec_size_m1 = IDX_W'(0);
      3'b001:  dec_size_m1 = IDX_W'(1);
      3'b010:  dec_size_m1 = IDX_W'(3);
      3'b011:  dec_size_m1 = IDX_W'(7);
      3'b100:  dec_rsvd    = 1'b1;
      default: dec_size_m1 = IDX_W'(0);
    endcase
  end

  assign align_mask = {{(ADDR_W-IDX_W){1'b0}}, dec_size_m1};

  assign dec_misalign = |(bus.in_raA & align_mask)
                      | |(bus.in_raB & align_mask)
                      | |(bus.in_rdest & align_mask);

  assign dec_bad = dec_rsvd | dec_misalign;

  assign issuing  = (state == S_ISSUE);
  assign at_last  = (idx == size_m1);
  assign out_fire = issuing & bus.out_ready;

  // A group's last fire frees the slot the same cycle: no bubble.
  assign ready = !flush
               & (!issuing | (out_fire & at_last));
  assign in_fire = bus.in_valid & ready;

  assign bus.in_ready = ready;
  assign fetch_stall  = !ready;

  assign bus.out_valid = issuing;
  assign bus.out_idx   = idx;
  assign bus.out_raA   = base_a + ADDR_W'(idx);
  assign bus.out_raB   = base_b + ADDR_W'(idx);
  assign bus.out_rdest = base_d + ADDR_W'(idx);
  assign bus.out_first = issuing & (idx == '0);
  assign bus.out_last  = issuing & at_last;

  assign illegal = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base_a    <= '0;
      base_b    <= '0;
      base_d    <= '0;
      size_m1   <= '0;
      idx       <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= in_fire & dec_bad;
      if (in_fire && !dec_bad) begin
        state   <= S_ISSUE;
        base_a  <= bus.in_raA;
        base_b  <= bus.in_raB;
        base_d  <= bus.in_rdest;
        size_m1 <= dec_size_m1;
        idx     <= '0;
      end else if (out_fire) begin
        if (at_last) begin
          state <= S_IDLE;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  // Stalled micro-op must not change under the consumer.
  a_hold: assert property (
    @(posedge clk) disable iff (rst)
    (issuing && !bus.out_ready && !flush)
      |=> (bus.out_valid
           && $stable(bus.out_raA)
           && $stable(bus.out_raB)
           && $stable(bus.out_rdest)
           && $stable(bus.out_idx))
  );

  a_pulse: assert property (
    @(posedge clk) disable iff (rst)
    illegal |-> !bus.out_valid || $past(issuing)
  );

endmodule

// File: tb/tb_vgroup_sequencer.sv
// Directed and randomized checks of vgroup_sequencer against a
// queue-based model of the expanded micro-op stream.
module tb_vgroup_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic fetch_stall;
  logic illegal;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int a;
    int b;
    int d;
    int idx;
    bit first;
    bit last;
  } uop_t;

  uop_t q[$];
  bit   exp_ill = 1'b0;
  bit   post_rst = 1'b0;

  vgroup_sequencer_if #(.ADDR_W(5), .IDX_W(3)) bus ();

  vgroup_sequencer #(.ADDR_W(5), .MAX_LMUL(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .fetch_stall (fetch_stall),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic drive(bit v, int lm, int a, int b, int d);
    bus.in_valid = v;
    bus.in_lmul  = 3'(lm);
    bus.in_raA   = 5'(a);
    bus.in_raB   = 5'(b);
    bus.in_rdest = 5'(d);
  endtask

  // One clock cycle: check outputs, then advance the model.
  task automatic tick();
    bit e_ready;
    bit ofire;
    bit ifire;
    bit bad;
    int sz;
    int lm;
    int a;
    int b;
    int d;
    bit r;
    bit f;
    uop_t u;
    #1;
    e_ready = !flush
            && (q.size() == 0
                || (bus.out_ready && q.size() == 1));
    chk("in_ready", int'(bus.in_ready), int'(e_ready));
    chk("fetch_stall", int'(fetch_stall), int'(!e_ready));
    chk("out_valid", int'(bus.out_valid), int'(q.size() > 0));
    chk("illegal", int'(illegal), int'(exp_ill));
    if (q.size() > 0) begin
      chk("out_raA", int'(bus.out_raA), q[0].a);
      chk("out_raB", int'(bus.out_raB), q[0].b);
      chk("out_rdest", int'(bus.out_rdest), q[0].d);
      chk("out_idx", int'(bus.out_idx), q[0].idx);
      chk("out_first", int'(bus.out_first), int'(q[0].first));
      chk("out_last", int'(bus.out_last), int'(q[0].last));
    end else begin
      chk("idle_first", int'(bus.out_first), 0);
      chk("idle_last", int'(bus.out_last), 0);
      if (post_rst) begin
        chk("rst_raA", int'(bus.out_raA), 0);
        chk("rst_raB", int'(bus.out_raB), 0);
        chk("rst_rdest", int'(bus.out_rdest), 0);
        chk("rst_idx", int'(bus.out_idx), 0);
      end
    end
    ofire = q.size() > 0 && bus.out_ready;
    ifire = bus.in_valid && e_ready;
    lm = int'(bus.in_lmul);
    a  = int'(bus.in_raA);
    b  = int'(bus.in_raB);
    d  = int'(bus.in_rdest);
    r  = rst;
    f  = flush;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_ill  = 1'b0;
      post_rst = 1'b1;
    end else if (f) begin
      q.delete();
      exp_ill = 1'b0;
    end else begin
      if (ofire) void'(q.pop_front());
      sz  = (lm < 4) ? (1 << lm) : 1;
      bad = (lm == 4) || (a % sz != 0)
         || (b % sz != 0) || (d % sz != 0);
      exp_ill = ifire && bad;
      if (ifire && !bad) begin
        post_rst = 1'b0;
        for (int i = 0; i < sz; i++) begin
          u.a = a + i;
          u.b = b + i;
          u.d = d + i;
          u.idx = i;
          u.first = (i == 0);
          u.last = (i == sz - 1);
          q.push_back(u);
        end
      end
    end
    @(negedge clk);
  endtask

  int lm_r;
  int sz_r;

  initial begin
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    post_rst = 1'b1;

    // LMUL=1
    drive(1, 0, 3, 5, 7);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();

    // LMUL=4 with backpressure on the 2nd micro-op
    drive(1, 2, 8, 12, 16);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    bus.out_ready = 1'b0;
    repeat (2) tick();
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Back-to-back LMUL=2 then LMUL=8
    drive(1, 1, 0, 2, 4);
    tick();
    drive(1, 3, 8, 16, 24);
    while (!bus.in_ready) tick();
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (9) tick();

    // Misaligned operand, then reserved encoding
    drive(1, 2, 8, 6, 16);
    tick();
    drive(1, 4, 1, 2, 3);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();

    // Flush on the 3rd micro-op of an LMUL=8 group
    drive(1, 3, 16, 8, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();
    flush = 1'b1;
    drive(1, 0, 1, 1, 1);
    tick();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) tick();

    // Reset mid-group
    drive(1, 2, 4, 8, 12);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      lm_r = int'($urandom_range(0, 7));
      sz_r = (lm_r < 4) ? (1 << lm_r) : 1;
      if ($urandom_range(0, 9) < 8) begin
        drive($urandom_range(0, 3) != 0, lm_r,
              int'($urandom_range(0, 31)) & ~(sz_r - 1),
              int'($urandom_range(0, 31)) & ~(sz_r - 1),
              int'($urandom_range(0, 31)) & ~(sz_r - 1));
      end else begin
        drive(1, lm_r,
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
